lag_averager: RTL
=================

# lag_averager

Parametrised streaming averager for unsigned sample streams with a selectable mode:
- **Pair mode:** averages each sample with the sample LAG positions earlier.
- **Window mode:** outputs the running mean of the last LAG samples.

It sits in the sample-processing path between a data source and any downstream consumer, with valid/ready handshakes on both sides. It replaces the fixed 8-bit, fixed-lag averager: width, lag and rounding are parameters, backpressure is supported, and a continuous circular buffer means there is no 128-sample batch limit.

## Interface
- WIDTH, 8: sample and result width in bits.
- LOG_LAG, 3: LAG = 2**LOG_LAG. Pair distance and window length, in samples.
- ROUND, 1: 1 = round half up; 0 = truncate.
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- flush  input  1  synchronous clear of history; also latches `mode`.
- mode  input  1  0 = pair average, 1 = window mean. Sampled only while `flush` = 1 or `reset` = 0.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  unsigned sample.
- out_valid  output  1  `out_data` is valid.
- out_ready  input  1  consumer accepts `out_data`.
- out_data  output  WIDTH  averaged result.

## Operation
- **Accept:** a sample is accepted on a rising edge with `in_valid` && `in_ready`.
  - Accepted samples are written into a LAG-deep circular buffer at `wr_ptr`; `wr_ptr` wraps from LAG-1 to 0.
  - The old entry at `wr_ptr` is x[n-LAG]. It is read before being overwritten.
- **Fill counter:** `fill` counts 0..LAG and saturates at LAG.
  - While `fill` < LAG, accepted samples produce no output (warm-up).
  - Output begins with the sample accepted when `fill` == LAG, i.e. sample index LAG, in both modes.
- **Pair mode:** result = (x[n] + x[n-LAG] + ROUND) >> 1.
  - The sum is WIDTH+1 bits wide, so there is no overflow; the result always fits in WIDTH bits.
- **Window mode:** running sum S, WIDTH+LOG_LAG bits wide.
  - Update on every accept: S <= S + x[n] - x[n-LAG]. During warm-up the evicted value is 0, because the buffer is zeroed on reset and on `flush`.
  - Result = (S_new + (ROUND ? LAG/2 : 0)) >> LOG_LAG.
  - The intermediate value uses WIDTH+LOG_LAG+1 bits; the result fits in WIDTH bits.
- **Mode control:** `mode` is held in a register `mode_q`, loaded during reset or on an edge with `flush` = 1. Changing the `mode` pin at any other time has no effect.
- **Flush:** zeroes `fill`, `wr_ptr`, S, every buffer entry and `out_valid`.
  - Any sample offered in the same cycle is dropped; `in_ready` is 0 while `flush` = 1.
- **Output register:** one stage.
  - `in_ready` = !`out_valid` || `out_ready`, forced to 0 while `flush` = 1.
  - `out_valid` sets on an accept that produces a result.
  - `out_valid` clears on `out_ready` with no new result.
  - Accept and drain in the same cycle: the register is overwritten and `out_valid` stays 1.

## Timing
- **Reset values:** `out_valid` = 0, `out_data` = 0, `in_ready` = 1 (once `reset` deasserts and `flush` = 0), `fill` = 0, S = 0, `wr_ptr` = 0, buffer all zero, `mode_q` = `mode` pin.
- **Latency:** a sample accepted at edge k puts its result on `out_data` with `out_valid` = 1 in the cycle after edge k.
- **Throughput:** 1 sample/cycle when `out_ready` is held at 1.
- **Output stability:** `out_data` and `out_valid` are stable while `out_valid` = 1 and `out_ready` = 0.
- **Reset mid-stream:** reset takes effect asynchronously and discards all history. The first output after release is sample index LAG.
- **Flush and reset:** `flush` takes precedence over any handshake in the same cycle. Reset takes precedence over `flush`.

## Structure
- **Package `avg_pkg`:**
  - mode encoding constants: `MODE_PAIR` = 0, `MODE_WIN` = 1.
  - a function computing the rounded shift.
- **Sub-module `lag_buffer`:** LAG x WIDTH circular delay line.
  - Ports: `wr_en`, `wr_data`, `old_data` (x[n-LAG], combinational read at `wr_ptr`), `clr`.
  - Owns `wr_ptr` and the zero-on-clear behaviour.
- **Top level:** `fill` counter, running sum S, arithmetic, output register and handshake.

## Test plan
1. **Reset:** assert `reset` = 0 mid-stream, then release -> `out_valid` = 0, `out_data` = 0, `in_ready` = 1; the next 8 samples produce no output.
2. **Pair mode, rounding** (WIDTH = 8, LOG_LAG = 3, ROUND = 1): feed 0..15 -> outputs appear for samples 8..15 with values 4..11.
   - Then x0 = 255, x8 = 254 -> output 255.
   - With ROUND = 0, x0 = 3, x8 = 4 -> output 3.
3. **Window mode:** seven samples of 10, then 18 -> S = 88, no output yet (warm-up).
   - Next sample 10 evicts x0 = 10 -> S = 88, output (88 + 4) >> 3 = 11.
4. **Backpressure:** hold `out_ready` = 0 for 5 cycles with `in_valid` = 1 -> `in_ready` = 0 and `out_data` stays stable; no samples are lost after release.
5. **Flush mid-stream with `mode` change** (pair -> window): the next 8 accepts produce no output.
   - A sample offered during the `flush` cycle is dropped.
   - The window-mode result follows.
6. **Simultaneous accept and drain:** `out_ready` = 1 and `in_valid` = 1 every cycle for 32 samples -> 1 result/cycle, `out_valid` never drops after warm-up, and values match a reference model.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared definitions for the lag averager: mode encoding and the rounded
// right-shift used by both averaging paths.
package avg_pkg;

    localparam logic MODE_PAIR = 1'b0;
    localparam logic MODE_WIN  = 1'b1;

    // Adds half an LSB of the shifted result before shifting when round_en is set.
    function automatic logic [31:0] round_shift(input logic [31:0] value,
                                                input int unsigned shift,
                                                input logic        round_en);
        logic [31:0] bias;
        bias = (round_en && shift > 0) ? (32'd1 << (shift - 1)) : 32'd0;
        return (value + bias) >> shift;
    endfunction

endpackage

// File: rtl/lag_buffer.sv
// LAG-deep circular delay line. old_data is the entry about to be
// overwritten, i.e. the sample accepted LAG writes ago (zero after clear).
module lag_buffer #(
    parameter int WIDTH   = 8,
    parameter int LOG_LAG = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] old_data
);

    localparam int LAG = 1 << LOG_LAG;

    logic [LOG_LAG-1:0] wr_ptr;
    logic [WIDTH-1:0]   mem [LAG];

    // LAG is a power of two, so the pointer wraps from LAG-1 to 0 on its own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            for (int i = 0; i < LAG; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            for (int i = 0; i < LAG; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
        end
    end

    assign old_data = mem[wr_ptr];

endmodule

// File: rtl/lag_averager.sv
// Streaming averager: pair mode averages x[n] with x[n-LAG], window mode
// outputs the running mean of the last LAG samples.
module lag_averager
    import avg_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LOG_LAG = 3,
    parameter int ROUND   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int                 LAG       = 1 << LOG_LAG;
    localparam int                 SW        = WIDTH + LOG_LAG;
    localparam logic [LOG_LAG:0]   FILL_FULL = (LOG_LAG + 1)'(LAG);

    logic             mode_q;
    logic [LOG_LAG:0] fill;
    logic [SW-1:0]    sum_q;
    logic [SW-1:0]    sum_new;
    logic [WIDTH-1:0] old_data;
    logic [WIDTH:0]   pair_sum;
    logic [WIDTH-1:0] pair_res;
    logic [WIDTH-1:0] win_res;
    logic             accept;
    logic             produce;

    // Handshake: a transfer happens on an edge where valid && ready. The
    // producer holds valid/data until the transfer; ready never depends on
    // valid of the same port. flush forces in_ready low so flush wins.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign produce  = accept && (fill == FILL_FULL);

    lag_buffer #(
        .WIDTH   (WIDTH),
        .LOG_LAG (LOG_LAG)
    ) u_buffer (
        .clk      (clk),
        .reset    (reset),
        .clr      (flush),
        .wr_en    (accept),
        .wr_data  (in_data),
        .old_data (old_data)
    );

    assign pair_sum = {1'b0, in_data} + {1'b0, old_data};
    // sum_q always contains old_data, so the subtraction cannot underflow.
    assign sum_new  = sum_q + SW'(in_data) - SW'(old_data);
    assign pair_res = WIDTH'(round_shift(32'(pair_sum), 1, ROUND != 0));
    assign win_res  = WIDTH'(round_shift(32'(sum_new), LOG_LAG, ROUND != 0));

    // Mode is captured on every clock while reset is held, and on flush edges.
    always_ff @(posedge clk) begin
        if (!reset || flush) mode_q <= mode;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill  <= '0;
            sum_q <= '0;
        end else if (flush) begin
            fill  <= '0;
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_new;
            if (fill != FILL_FULL) fill <= fill + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (produce) begin
            out_valid <= 1'b1;
            out_data  <= (mode_q == MODE_WIN) ? win_res : pair_res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
